// File: rtl/prefetch_fetch_unit_if.sv
// Fetch unit bus bundle: memory req/ack side, decode valid/ready side,
// redirect input and FIFO occupancy.
interface prefetch_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  MEM_REQ;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic                  MEM_ACK;
  logic [DATA_WIDTH-1:0] MEM_DATA;
  logic                  INST_VALID;
  logic                  INST_READY;
  logic [DATA_WIDTH-1:0] INSTRUCTION;
  logic [ADDR_WIDTH-1:0] INST_PC;
  logic                  REDIRECT;
  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR;
  logic [CW-1:0]         COUNT;

  modport master (
    output MEM_REQ, MEM_ADDR,
    input  MEM_ACK, MEM_DATA,
    output INST_VALID, INSTRUCTION, INST_PC,
    input  INST_READY,
    input  REDIRECT, REDIRECT_ADDR,
    output COUNT
  );

  modport slave (
    input  MEM_REQ, MEM_ADDR,
    output MEM_ACK, MEM_DATA,
    input  INST_VALID, INSTRUCTION, INST_PC,
    output INST_READY,
    output REDIRECT, REDIRECT_ADDR,
    input  COUNT
  );
endinterface

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetch front end: owns the PC, fetches words over req/ack
// and queues {pc, word} pairs in a flushable FIFO feeding decode.
module prefetch_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'h0001000
) (
  input  logic CLK,
  input  logic RST,
  prefetch_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]         pc_q   [DEPTH];
  logic push, pop, room;

  always_comb begin
    push = (state_q == WAIT) && bus.MEM_ACK
        && !bus.REDIRECT;
    pop  = (count_q != '0) && bus.INST_READY
        && !bus.REDIRECT;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    fetch_pc_d = fetch_pc_q;
    if (push) fetch_pc_d = fetch_pc_q + AW'(1);
    // redirect flushes everything and wins over push/pop
    if (bus.REDIRECT) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.REDIRECT_ADDR;
    end
    room = count_d < CW'(DEPTH);
    // the abandoned request keeps its address on the bus
    hold_addr_d = (state_q == DISCARD) ? hold_addr_q
                                       : fetch_pc_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.REDIRECT && room) state_d = WAIT;
      end
      WAIT: begin
        if (bus.REDIRECT)
          state_d = bus.MEM_ACK ? IDLE : DISCARD;
        else if (bus.MEM_ACK)
          state_d = room ? WAIT : IDLE;
      end
      DISCARD: begin
        if (bus.MEM_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      fetch_pc_q  <= START_ADDR;
      hold_addr_q <= START_ADDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= bus.MEM_DATA;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign bus.MEM_REQ     = (state_q != IDLE);
  assign bus.MEM_ADDR    = (state_q == DISCARD) ? hold_addr_q
                                                : fetch_pc_q;
  assign bus.INST_VALID  = (count_q != '0);
  assign bus.INSTRUCTION = data_q[rd_ptr_q];
  assign bus.INST_PC     = pc_q[rd_ptr_q];
  assign bus.COUNT       = count_q;
endmodule
